// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment display scanner.
package seven_seg_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_t;

    localparam seg_t SEG_BLANK  = 7'b0000000;
    localparam seg_t SEG_DASH   = 7'b1000000;
    localparam int   NUM_DIGITS = 6;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-high {g,f,e,d,c,b,a} pattern; non-decimal codes show a dash.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = 7'b0111111;
            4'd1: seg = 7'b0000110;
            4'd2: seg = 7'b1011011;
            4'd3: seg = 7'b1001111;
            4'd4: seg = 7'b1100110;
            4'd5: seg = 7'b1101101;
            4'd6: seg = 7'b1111101;
            4'd7: seg = 7'b0000111;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1101111;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes six snapshotted BCD digits onto a seven-segment display with
// leading-zero blanking, blinking and a one-cycle anti-ghosting gap between digits.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count0,
    input  logic [3:0] count1,
    input  logic [3:0] count2,
    input  logic [3:0] count3,
    input  logic [3:0] count4,
    input  logic [3:0] count5,
    input  logic       enable,
    input  logic [5:0] flashMask,
    input  logic       remind,
    output logic [6:0] segments,
    output logic       dp,
    output logic [5:0] anodes,
    output logic [2:0] selectLine,
    output logic       frameStart
);

    localparam int PRE_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    scan_state_t        state, state_next;
    logic [2:0]         sel, sel_next;
    logic [PRE_W-1:0]   prescaler, pre_next;
    logic [BLINK_W-1:0] blink_count, blink_count_next;
    logic               blink_phase, phase_next;
    bcd_t               shadow [NUM_DIGITS];
    bcd_t               count_in [NUM_DIGITS];

    logic               snap;
    bcd_t               digit_next;
    seg_t               decoded;
    logic               blank;
    seg_t               seg_next;
    logic               dp_next;
    logic [5:0]         an_next;

    seg_t               seg_p1;
    logic               dp_p1;
    logic [5:0]         an_p1;

    assign count_in[0] = count0;
    assign count_in[1] = count1;
    assign count_in[2] = count2;
    assign count_in[3] = count3;
    assign count_in[4] = count4;
    assign count_in[5] = count5;

    // The GAP ahead of digit 0 is the frame boundary: snapshot and blink tick.
    assign snap       = (state == GAP) && (sel == 3'd0);
    assign frameStart = snap && !reset;

    always_comb begin
        state_next = state;
        sel_next   = sel;
        pre_next   = prescaler;
        case (state)
            GAP: begin
                state_next = SHOW;
                pre_next   = '0;
            end
            SHOW: begin
                if (prescaler == PRE_LAST) begin
                    state_next = GAP;
                    pre_next   = '0;
                    sel_next   = (sel == 3'd5) ? 3'd0 : sel + 3'd1;
                end else begin
                    pre_next = prescaler + 1'b1;
                end
            end
            default: state_next = GAP;
        endcase
    end

    always_comb begin
        blink_count_next = blink_count;
        phase_next       = blink_phase;
        if (snap) begin
            if (blink_count == BLINK_LAST) begin
                blink_count_next = '0;
                phase_next       = ~blink_phase;
            end else begin
                blink_count_next = blink_count + 1'b1;
            end
        end
    end

    // Outputs are registered, so they are computed from the state being entered;
    // digit 0 must see the snapshot taken on this very edge.
    assign digit_next = snap ? count_in[sel_next] : shadow[sel_next];

    bcd_to_seg u_dec (
        .bcd (digit_next),
        .seg (decoded)
    );

    always_comb begin
        blank = !enable
             || ((sel_next == 3'd5) && (digit_next == 4'd0))
             || ((flashMask[sel_next] || remind) && phase_next);
        seg_next = SEG_BLANK;
        dp_next  = 1'b0;
        an_next  = '0;
        if ((state_next == SHOW) && !blank) begin
            seg_next = decoded;
            dp_next  = (sel_next == 3'd2) || (sel_next == 3'd4);
            an_next  = 6'd1 << sel_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= GAP;
            sel         <= '0;
            prescaler   <= '0;
            blink_count <= '0;
            blink_phase <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
            seg_p1      <= {7{ACTIVE_LOW}};
            dp_p1       <= ACTIVE_LOW;
            an_p1       <= {6{ACTIVE_LOW}};
        end else begin
            state       <= state_next;
            sel         <= sel_next;
            prescaler   <= pre_next;
            blink_count <= blink_count_next;
            blink_phase <= phase_next;
            if (snap) begin
                for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= count_in[i];
            end
            seg_p1      <= seg_next ^ {7{ACTIVE_LOW}};
            dp_p1       <= dp_next ^ ACTIVE_LOW;
            an_p1       <= an_next ^ {6{ACTIVE_LOW}};
        end
    end

    assign segments   = seg_p1;
    assign dp         = dp_p1;
    assign anodes     = an_p1;
    assign selectLine = sel;

endmodule
